// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the M-extension multiply/divide unit:
// opcode/funct7 of M instructions, funct3 operation codes, FSM encoding
// and the two 32-bit constants used by the divide special cases.
package riscv_pkg;

  localparam logic [6:0]  OPCODE_OP     = 7'b0110011;
  localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // True when an R-type instruction belongs to the M extension.
  function automatic logic is_m_instr(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// One restoring-divide step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it did not
// go negative and shift the resulting quotient bit in. Purely combinational.
module muldiv_div_core (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [33:0] diff;
  logic        ge;

  // Trial subtraction; partial remainder is always below the divisor, so
  // the shifted value fits in 33 bits and a kept difference fits in 32.
  always_comb begin
    shifted = {rem_i, quo_i[31]};
    diff    = {1'b0, shifted} - {2'b00, divisor_i};
    ge      = ~diff[33];
    rem_o   = ge ? diff[31:0] : shifted[31:0];
    quo_o   = {quo_i[30:0], ge};
  end

endmodule

// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit in EX: iterates 32 cycles on operand magnitudes
// (shift-add multiply, restoring divide), stalls the pipe via busy and
// presents a registered result for the one cycle done is high.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiplier, 2-cycle multiplies.
module ex_muldiv
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3e,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  md_state_e   state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic        neg_q;
  logic        done_q;
  logic [31:0] result_q;

  logic        a_signed, b_signed, sa, sb;
  logic [31:0] a_mag, b_mag;
  logic        is_div, div_by_zero, sovf, neg_start;
  logic [31:0] special_res;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [31:0] div_rem, div_quo;
  logic [63:0] acc_d;
  logic [63:0] mul_fix;
  logic [31:0] div_sel, div_fix, fin_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] fast_a, fast_b, fast_prod;
  logic [31:0]        fast_res;
`endif

  // Operand decode in IDLE: signedness, magnitudes and special cases.
  always_comb begin
    a_signed    = funct3e[2] ? ~funct3e[0] : (funct3e != F3_MULHU);
    b_signed    = funct3e[2] ? ~funct3e[0] : ~funct3e[1];
    sa          = a_signed & srca[31];
    sb          = b_signed & srcb[31];
    a_mag       = sa ? (~srca + 32'd1) : srca;
    b_mag       = sb ? (~srcb + 32'd1) : srcb;
    is_div      = funct3e[2];
    div_by_zero = is_div & (srcb == 32'd0);
    sovf        = is_div & ~funct3e[0] & (srca == INT_MIN) & (srcb == ALL_ONES);
    // Remainder takes the dividend's sign; everything else takes sign(a)^sign(b).
    neg_start   = (is_div & funct3e[1]) ? sa : (sa ^ sb);
    if (div_by_zero) begin
      special_res = funct3e[1] ? srca : ALL_ONES;
    end else begin
      special_res = funct3e[1] ? 32'd0 : INT_MIN;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product; only the low 64 bits are ever needed.
  always_comb begin
    fast_a    = {{32{sa}}, srca};
    fast_b    = {{32{sb}}, srcb};
    fast_prod = fast_a * fast_b;
    fast_res  = (funct3e == F3_MUL) ? fast_prod[31:0] : fast_prod[63:32];
  end
`endif

  muldiv_div_core u_div_core (
    .rem_i     (acc_q[63:32]),
    .quo_i     (acc_q[31:0]),
    .divisor_i (opb_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  // One iteration step and the sign fix-up of the value it produces, so the
  // final result can be registered on the edge of the last iteration.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    acc_d    = op_q[2] ? {div_rem, div_quo} : mul_next;
    mul_fix  = neg_q ? (64'd0 - acc_d) : acc_d;
    div_sel  = op_q[1] ? acc_d[63:32] : acc_d[31:0];
    div_fix  = neg_q ? (32'd0 - div_sel) : div_sel;
    if (op_q[2]) begin
      fin_res = div_fix;
    end else if (op_q == F3_MUL) begin
      fin_res = mul_fix[31:0];
    end else begin
      fin_res = mul_fix[63:32];
    end
  end

  // Stall request: the cycle IDLE accepts an op, and every BUSY cycle.
  always_comb begin
    busy = ((state_q == ST_IDLE) & start & ~flush) | (state_q == ST_BUSY);
  end

  assign done   = done_q;
  assign result = result_q;

  // Control FSM with registered done/result; flush wins in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
        cnt_q   <= 5'd0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              op_q  <= funct3e;
              neg_q <= neg_start;
              opb_q <= b_mag;
              acc_q <= {32'd0, a_mag};
              cnt_q <= 5'd0;
              if (div_by_zero | sovf) begin
                result_q <= special_res;
                done_q   <= 1'b1;
                state_q  <= ST_DONE;
              end
`ifdef MULDIV_FAST_MUL_EN
              else if (!is_div) begin
                result_q <= fast_res;
                done_q   <= 1'b1;
                state_q  <= ST_DONE;
              end
`endif
              else begin
                state_q <= ST_BUSY;
              end
            end
          end
          ST_BUSY: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              result_q <= fin_res;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
          ST_DONE: begin
            // A start still held here belongs to the finishing instruction.
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed M-extension cases, random ops
// against an arithmetic reference, back-to-back issue, flush and reset.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3e;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  ex_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3e (funct3e),
    .srca    (srca),
    .srcb    (srcb),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  // RV32M semantics computed with plain wide arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x, y, p;
    logic [63:0]        pu;
    logic signed [31:0] sa, sb, sq;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    x   = {{32{a[31]}}, a};
    case (op)
      3'd0: begin y = {{32{b[31]}}, b}; p = x * y; return p[31:0]; end
      3'd1: begin y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
      3'd2: begin y = {32'd0, b}; p = x * y; return p[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        sq = sa / sb; return sq;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        sq = sa % sb; return sq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycle of done relative to the accepting cycle.
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!op[2] && FAST) return 1;
    return 33;
  endfunction

  // Issues one op and follows it to done; start is left high on return.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res;
    int          lat;
    bit          seen;
    exp_res = ref_result(op, a, b);
    lat     = ref_latency(op, a, b);
    @(negedge clk);
    start = 1'b1; funct3e = op; srca = a; srcb = b; flush = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_c0 op=%0d got %b want 1", op, busy);
    end
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (k != lat) begin
          errors++; $display("FAIL latency op=%0d a=%h b=%h got %0d want %0d", op, a, b, k, lat);
        end
        checks++;
        if (result !== exp_res) begin
          errors++; $display("FAIL result op=%0d a=%h b=%h got %h want %h", op, a, b, result, exp_res);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL busy_done op=%0d got %b want 0", op, busy);
        end
      end else begin
        checks++;
        if (busy !== (k < lat)) begin
          errors++; $display("FAIL busy_c%0d op=%0d got %b want %b", k, op, busy, (k < lat));
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL timeout op=%0d a=%h b=%h got no done want done", op, a, b);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3e = 3'd0; srca = 32'd0; srcb = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3);           // DIV -20/3
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3);           // REM
    idle_cycle();
    run_op(3'd5, 32'h0000_1234, 32'd0);           // DIVU by zero
    run_op(3'd7, 32'h0000_1234, 32'd0);           // REMU by zero
    idle_cycle();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);   // DIV overflow
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);   // REM overflow
    idle_cycle();
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // MULH
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // MULHU
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // MULHSU
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000);   // MUL of INT_MIN
    idle_cycle();
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(op, a, b);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_flush();
    int done_seen;
    @(negedge clk);
    start = 1'b1; funct3e = 3'd4; srca = 32'hFFFF_FFEC; srcb = 32'd3; flush = 1'b0;
    repeat (10) @(negedge clk);                  // now in cycle 10
    flush = 1'b1; start = 1'b0;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);                              // cycle 11
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) done_seen++;
      @(negedge clk);
    end
    checks++;
    if (done_seen != 0) begin errors++; $display("FAIL flush_done got %0d done cycles want 0", done_seen); end
    run_op(3'd5, 32'd1000, 32'd7);
    idle_cycle();
  endtask

  task automatic test_rst_mid_busy();
    @(negedge clk);
    start = 1'b1; funct3e = 3'd4; srca = 32'hFFFF_FFEC; srcb = 32'd3; flush = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++;
    if (result !== 32'd0) begin errors++; $display("FAIL rst_result got %h want 0", result); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3);
    idle_cycle();
  endtask

  initial begin
    test_reset();
    // Seed result with a nonzero value so the reset-mid-op check is meaningful.
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3);
    idle_cycle();
    test_directed();
    test_random();
    test_flush();
    test_rst_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
